// File: rtl/period_meter.sv
// period_meter: measures the rise-to-rise period of sig_in in clk cycles.
// It reports the last period, a one-cycle valid pulse, a match against
// EXPECT_PERIOD, a sticky counter-saturation flag, and a lock indication
// after two consecutive equal measurements.
// Optional build macro INPUT_SYNC_EN: sig_in passes through a two-flop
// synchronizer before edge detection. This adds two cycles of latency and
// does not change the measured periods.
module period_meter #(
    parameter int WIDTH         = 8,
    parameter int EXPECT_PERIOD = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             match,
    output logic             overflow,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic sig_s;      // sig_in as seen by the edge detector
    logic prev_q;     // sig_s from the previous clk edge
    logic rise;

`ifdef INPUT_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer in front of the edge detector.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the two stages into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

    assign sig_s = sync2_q;
`else
    assign sig_s = sig_in;
`endif

    // Edge detector history: remembers the last sampled level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_s;
        end
    end

    assign rise = sig_s & ~prev_q;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d;
    logic             locked_q, locked_d;

    // Next-state logic: FSM transitions, period counter and result flags.
    // Dropping en wins over everything. A rise wins over saturation, so a
    // period of exactly CNT_MAX is still reported.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        match_d  = match_q;
        ovf_d    = ovf_q;
        locked_d = locked_q;

        if (!en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        match_d  = (32'(cnt_q) == EXPECT_PERIOD);
                        valid_d  = 1'b1;
                        locked_d = (cnt_q == period_q);
                        cnt_d    = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = ARM;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and result registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
            ovf_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            ovf_q    <= ovf_d;
            locked_q <= locked_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign match        = match_q;
    assign overflow     = ovf_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter. Every clk cycle is compared against
// a timestamp-based reference model. A hand-computed vector table and
// directed sequences cover the multi-cycle corner cases.
module tb_period_meter;

    localparam int WIDTH = 8;
    localparam int EXP_P = 20;
    localparam int MAXC  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             match;
    logic             overflow;
    logic             locked;

    period_meter #(.WIDTH(WIDTH), .EXPECT_PERIOD(EXP_P)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .match        (match),
        .overflow     (overflow),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int dut_valids = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the time of the last rise and derives the
    // period as a timestamp difference.
    typedef enum {M_IDLE, M_ARM, M_MEAS} mstate_e;
    mstate_e m_state;
    int      m_now = 0;
    int      m_last;
    int      m_period;
    logic    m_prev, m_s1, m_s2;
    logic    m_valid, m_match, m_ovf, m_locked;

    task automatic model_reset();
        m_state  = M_IDLE;
        m_last   = 0;
        m_period = 0;
        m_prev   = 1'b0;
        m_s1     = 1'b0;
        m_s2     = 1'b0;
        m_valid  = 1'b0;
        m_match  = 1'b0;
        m_ovf    = 1'b0;
        m_locked = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic s);
        logic samp;
        logic rise;
        int   k;
        m_now++;
        if (!rst) begin
            model_reset();
            return;
        end
`ifdef INPUT_SYNC_EN
        samp = m_s2;
        m_s2 = m_s1;
        m_s1 = s;
`else
        samp = s;
`endif
        rise    = samp && !m_prev;
        m_prev  = samp;
        m_valid = 1'b0;
        if (!e) begin
            m_state  = M_IDLE;
            m_locked = 1'b0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    m_state = M_ARM;
                    m_ovf   = 1'b0;
                end
                M_ARM: begin
                    if (rise) begin
                        m_state = M_MEAS;
                        m_last  = m_now;
                    end
                end
                default: begin
                    k = m_now - m_last;
                    if (rise) begin
                        m_valid  = 1'b1;
                        m_locked = (k == m_period);
                        m_period = k;
                        m_match  = (k == EXP_P);
                        m_last   = m_now;
                    end else if (k == MAXC) begin
                        m_ovf    = 1'b1;
                        m_locked = 1'b0;
                        m_state  = M_ARM;
                    end
                end
            endcase
        end
    endtask

    // One clk cycle: drive inputs, let the edge happen, compare #1 later.
    task automatic step(input logic e, input logic s);
        en     = e;
        sig_in = s;
        @(posedge clk);
        model_edge(e, s);
        #1;
        check("period_valid", period_valid, m_valid);
        check("period", period, m_period);
        check("match", match, m_match);
        check("overflow", overflow, m_ovf);
        check("locked", locked, m_locked);
        if (period_valid) dut_valids++;
    endtask

    // nper periods of 2*half cycles, each starting with a rise.
    task automatic square(input logic e, input int half, input int nper);
        for (int p = 0; p < nper; p++)
            for (int i = 0; i < 2 * half; i++)
                step(e, (i < half));
    endtask

    typedef struct {
        logic en;
        logic sig;
        logic valid;
        int   period;
        logic locked;
    } vec_t;

    vec_t tbl[13];
    int   base;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Hand-computed: 4-cycle square after arming, then enable drop.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 4, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 4, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 4, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 4, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 4, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 4, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 4, 1'b0};

        rst    = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        model_reset();
        #2;
        check("reset_period", period, 0);
        check("reset_valid", period_valid, 0);
        check("reset_match", match, 0);
        check("reset_overflow", overflow, 0);
        check("reset_locked", locked, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].en, tbl[i].sig);
`ifndef INPUT_SYNC_EN
            check("tbl_valid", period_valid, tbl[i].valid);
            check("tbl_period", period, tbl[i].period);
            check("tbl_locked", locked, tbl[i].locked);
`endif
        end

        // Basic measurement: period 20 matches, lock after second valid.
        base = dut_valids;
        step(1'b1, 1'b0);
        square(1'b1, 10, 2);
        check("basic_nvalid", dut_valids - base, 1);
        check("basic_period", period, 20);
        check("basic_match", match, 1);
        check("basic_locked0", locked, 0);
        square(1'b1, 10, 1);
        check("basic_nvalid2", dut_valids - base, 2);
        check("basic_locked1", locked, 1);

        // Period change to 14.
        square(1'b1, 7, 1);
        square(1'b1, 7, 1);
        check("chg_period", period, 14);
        check("chg_match", match, 0);
        check("chg_locked0", locked, 0);
        square(1'b1, 7, 1);
        check("chg_locked1", locked, 1);

        // Overflow: hold low long past saturation.
        base = dut_valids;
        repeat (300) step(1'b1, 1'b0);
        check("ovf_flag", overflow, 1);
        check("ovf_period_held", period, 14);
        check("ovf_no_valid", dut_valids - base, 0);
        check("ovf_locked", locked, 0);

        // Enable drop mid-period, then re-enable.
        base = dut_valids;
        repeat (5) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check("endrop_no_valid", dut_valids - base, 0);
        check("endrop_locked", locked, 0);
        check("endrop_ovf_held", overflow, 1);
        step(1'b1, 1'b0);
        check("reen_ovf_clear", overflow, 0);
        square(1'b1, 10, 1);
        check("reen_first_rise", dut_valids - base, 0);
        square(1'b1, 10, 1);
        check("reen_second_rise", dut_valids - base, 1);
        check("reen_period", period, 20);

        // Rise coinciding with a saturated counter reports 2^WIDTH-1.
        base = dut_valids;
        step(1'b1, 1'b1);
        repeat (254) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        check("max_nvalid", dut_valids - base, 2);
        check("max_period", period, MAXC);
        check("max_no_ovf", overflow, 0);

        // Asynchronous reset mid-measurement.
        repeat (5) step(1'b1, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("areset_period", period, 0);
        check("areset_valid", period_valid, 0);
        check("areset_match", match, 0);
        check("areset_overflow", overflow, 0);
        check("areset_locked", locked, 0);
        repeat (3) step(1'b1, 1'b0);
        #2 rst = 1'b1;
        base = dut_valids;
        step(1'b1, 1'b0);
        square(1'b1, 10, 2);
        check("restart_nvalid", dut_valids - base, 1);
        check("restart_period", period, 20);

        // Random segments against the model.
        repeat (60) begin
            logic e;
            int   h;
            int   n;
            e = ($urandom_range(0, 9) != 0);
            h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(120, 140))
                                             : int'($urandom_range(1, 15));
            n = $urandom_range(1, 3);
            square(e, h, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
